// File: rtl/complex_sample_fifo_sc.sv
// Single-clock FIFO for complex {I,Q} samples with level, almost-full/empty and sticky error flags.
// Optional peak-occupancy watermark enabled by defining COMPLEX_FIFO_WATERMARK_EN.
module complex_sample_fifo_sc #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [2*DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  output logic [2*DATA_WIDTH-1:0] rd_data_o,
  output logic                    rd_valid_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  input  logic [ADDR_WIDTH:0]     af_thresh_i,
  input  logic [ADDR_WIDTH:0]     ae_thresh_i,
  output logic [ADDR_WIDTH:0]     level_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  input  logic                    clr_flags_i,
  output logic [ADDR_WIDTH:0]     max_level_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [2*DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [2*DATA_WIDTH-1:0] r_rd_data;
  logic [ADDR_WIDTH:0]     r_wr_ptr, r_rd_ptr, r_level;
  logic                    r_full, r_empty, r_af, r_ae, r_rd_valid, r_ovf, r_udf;

  logic                    w_wr_acc, w_rd_acc;
  logic [ADDR_WIDTH:0]     w_wr_ptr_next, w_rd_ptr_next, w_next_level;
  logic                    w_full_next, w_empty_next;

  // Requests seen during reset are dropped entirely.
  assign w_wr_acc      = wr_en_i & ~r_full  & ~rst_i;
  assign w_rd_acc      = rd_en_i & ~r_empty & ~rst_i;
  assign w_wr_ptr_next = r_wr_ptr + (ADDR_WIDTH+1)'(w_wr_acc);
  assign w_rd_ptr_next = r_rd_ptr + (ADDR_WIDTH+1)'(w_rd_acc);
  assign w_next_level  = r_level + (ADDR_WIDTH+1)'(w_wr_acc) - (ADDR_WIDTH+1)'(w_rd_acc);
  assign w_empty_next  = (w_wr_ptr_next == w_rd_ptr_next);
  assign w_full_next   = (w_wr_ptr_next[ADDR_WIDTH-1:0] == w_rd_ptr_next[ADDR_WIDTH-1:0]) &&
                         (w_wr_ptr_next[ADDR_WIDTH] != w_rd_ptr_next[ADDR_WIDTH]);

  always_ff @(posedge clk_i) begin
    if (w_wr_acc)
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data_i;
  end

  // Registered read port; the synchronous reset maps onto the RAM output register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_rd_data <= '0;
    else if (w_rd_acc)
      r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_af       <= (af_thresh_i == '0);
      r_ae       <= 1'b1;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_next;
      r_rd_ptr   <= w_rd_ptr_next;
      r_level    <= w_next_level;
      r_full     <= w_full_next;
      r_empty    <= w_empty_next;
      r_af       <= (w_next_level >= af_thresh_i);
      r_ae       <= (w_next_level <= ae_thresh_i);
      r_rd_valid <= w_rd_acc;
      // A new error in the same cycle as a clear keeps the flag set.
      if (wr_en_i && r_full)
        r_ovf <= 1'b1;
      else if (clr_flags_i)
        r_ovf <= 1'b0;
      if (rd_en_i && r_empty)
        r_udf <= 1'b1;
      else if (clr_flags_i)
        r_udf <= 1'b0;
    end
  end

`ifdef COMPLEX_FIFO_WATERMARK_EN
  logic [ADDR_WIDTH:0] r_max_level;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_max_level <= '0;
    else if (clr_flags_i)
      r_max_level <= w_next_level;
    else if (w_next_level > r_max_level)
      r_max_level <= w_next_level;
  end

  assign max_level_o = r_max_level;
`else
  assign max_level_o = '0;
`endif

  assign rd_data_o      = r_rd_data;
  assign rd_valid_o     = r_rd_valid;
  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_af;
  assign almost_empty_o = r_ae;
  assign level_o        = r_level;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_udf;

endmodule
